// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Purpose  : Shared types and constants for the mm_bridge slice: the command
//            kind carried in the bridge's command register, the data word
//            returned for a read that the downstream side never answered, and
//            the default values of the bridge parameters.
// Revision : 1.0 - initial release
// ============================================================================
package mm_pkg;

   typedef enum logic {
      CMD_READ  = 1'b0,
      CMD_WRITE = 1'b1
   } cmd_kind_e;

   // Returned to the JTAG master in place of a read that timed out.
   localparam logic [31:0] c_default_rdata = 32'hDEADBEEF;

   localparam int c_def_addr_w         = 32;
   localparam int c_def_data_w         = 32;
   localparam int c_def_max_pending    = 4;
   localparam int c_def_timeout_cycles = 255;

endpackage
`default_nettype wire

// File: rtl/mm_read_tracker.sv
`default_nettype none
// ============================================================================
// Module   : mm_read_tracker
// Purpose  : Counts reads issued downstream but not yet answered, tells the
//            bridge when another read may be issued, and filters out responses
//            that arrive with nothing outstanding. With MM_BRIDGE_TIMEOUT_EN
//            defined it also runs a watchdog that synthesises a response for
//            a read that is never answered.
// Ports    : clk, rst (sync, active-low)
//            rd_issue     in  - a read is accepted downstream this cycle
//            rsp_valid    in  - m_readdatavalid from the register bank
//            slot_free    out - pending < MAX_PENDING
//            rsp_accept   out - rsp_valid that matches an outstanding read
//            rsp_timeout  out - watchdog expired this cycle (macro only)
//            timeout_flag out - sticky, set on the first synthesised response
// Revision : 1.0 - initial release
// ============================================================================
module mm_read_tracker
   import mm_pkg::*;
#(
   parameter int MAX_PENDING    = c_def_max_pending,
   parameter int TIMEOUT_CYCLES = c_def_timeout_cycles
) (
   input  logic clk,
   input  logic rst,
   input  logic rd_issue,
   input  logic rsp_valid,
   output logic slot_free,
   output logic rsp_accept,
   output logic rsp_timeout,
   output logic timeout_flag
);

   localparam int              PEND_W     = $clog2(MAX_PENDING + 1);
   localparam logic [PEND_W-1:0] c_max_pend = PEND_W'(MAX_PENDING);

   if (MAX_PENDING < 1 || MAX_PENDING > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("mm_read_tracker: MAX_PENDING must be 1..15 and TIMEOUT_CYCLES >= 1");
   end

   logic [PEND_W-1:0] pending_q, pending_d;
   logic              w_pend_nz;
   logic              w_dec;

   always_comb begin
      w_pend_nz  = (pending_q != '0);
      slot_free  = (pending_q < c_max_pend);
      rsp_accept = rsp_valid & w_pend_nz;
      w_dec      = rsp_accept | rsp_timeout;
      pending_d  = pending_q;
      // The bridge only issues a read while slot_free, so the increment can
      // never push the count past MAX_PENDING.
      case ({rd_issue, w_dec})
         2'b10:   pending_d = pending_q + 1'b1;
         2'b01:   pending_d = pending_q - 1'b1;
         default: pending_d = pending_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) pending_q <= '0;
      else      pending_q <= pending_d;
   end

`ifdef MM_BRIDGE_TIMEOUT_EN
   localparam int             WD_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] c_wd_limit = WD_W'(TIMEOUT_CYCLES);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            tflag_q, tflag_d;
   logic            w_expire;

   always_comb begin
      // A genuine response in the expiry cycle wins: no synthetic one then.
      w_expire = w_pend_nz & ~rsp_valid & (wd_q == c_wd_limit);
      wd_d     = wd_q + 1'b1;
      if (!w_pend_nz || rsp_valid || w_expire) wd_d = '0;
      tflag_d  = tflag_q | w_expire;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wd_q    <= '0;
         tflag_q <= 1'b0;
      end else begin
         wd_q    <= wd_d;
         tflag_q <= tflag_d;
      end
   end

   assign rsp_timeout  = w_expire;
   assign timeout_flag = tflag_q;
`else
   assign rsp_timeout  = 1'b0;
   assign timeout_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/mm_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mm_bridge
// Purpose  : Memory-mapped bridge between the JTAG master (s_*) and the
//            register bank (m_*). A one-entry command register drives the
//            master side; capture and issue may happen in the same cycle, so
//            sustained throughput is one command per cycle. Read responses
//            are forwarded with one register stage.
// Ports    : clk, rst (sync, active-low)
//            s_address/s_read/s_write/s_writedata/s_byteenable in,
//            s_waitrequest/s_readdata/s_readdatavalid out
//            m_address/m_read/m_write/m_writedata/m_byteenable out,
//            m_waitrequest/m_readdata/m_readdatavalid in
//            timeout_flag out - sticky, a read response was synthesised
// Config   : MM_BRIDGE_TIMEOUT_EN enables the read-response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mm_bridge
   import mm_pkg::*;
#(
   parameter int ADDR_W         = c_def_addr_w,
   parameter int DATA_W         = c_def_data_w,
   parameter int MAX_PENDING    = c_def_max_pending,
   parameter int TIMEOUT_CYCLES = c_def_timeout_cycles
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   s_address,
   input  logic                s_read,
   input  logic                s_write,
   input  logic [DATA_W-1:0]   s_writedata,
   input  logic [DATA_W/8-1:0] s_byteenable,
   output logic                s_waitrequest,
   output logic [DATA_W-1:0]   s_readdata,
   output logic                s_readdatavalid,
   output logic [ADDR_W-1:0]   m_address,
   output logic                m_read,
   output logic                m_write,
   output logic [DATA_W-1:0]   m_writedata,
   output logic [DATA_W/8-1:0] m_byteenable,
   input  logic                m_waitrequest,
   input  logic [DATA_W-1:0]   m_readdata,
   input  logic                m_readdatavalid,
   output logic                timeout_flag
);

   localparam int BE_W = DATA_W / 8;

   logic              cmd_valid_q, cmd_valid_d;
   cmd_kind_e         cmd_kind_q,  cmd_kind_d;
   logic [ADDR_W-1:0] cmd_addr_q,  cmd_addr_d;
   logic [DATA_W-1:0] cmd_data_q,  cmd_data_d;
   logic [BE_W-1:0]   cmd_be_q,    cmd_be_d;
   logic              rdv_q,       rdv_d;
   logic [DATA_W-1:0] rdata_q,     rdata_d;

   logic w_is_read;
   logic w_slot_free;
   logic w_issue;
   logic w_capture;
   logic w_rsp_accept;
   logic w_rsp_timeout;

   mm_read_tracker #(
      .MAX_PENDING    (MAX_PENDING),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .rd_issue     (w_issue & w_is_read),
      .rsp_valid    (m_readdatavalid),
      .slot_free    (w_slot_free),
      .rsp_accept   (w_rsp_accept),
      .rsp_timeout  (w_rsp_timeout),
      .timeout_flag (timeout_flag)
   );

   // Handshake. Everything is gated by rst so the bus is quiet while reset is
   // held, even before the first clock edge clears the command register.
   always_comb begin
      w_is_read     = (cmd_kind_q == CMD_READ);
      w_issue       = rst & cmd_valid_q & ~m_waitrequest & (~w_is_read | w_slot_free);
      s_waitrequest = rst & cmd_valid_q & ~w_issue;
      w_capture     = rst & (s_read | s_write) & ~s_waitrequest;

      // m_read must not depend on m_waitrequest; it only drops while the
      // outstanding-read limit is reached.
      m_read        = rst & cmd_valid_q & w_is_read & w_slot_free;
      m_write       = rst & cmd_valid_q & ~w_is_read;
      m_address     = cmd_addr_q;
      m_writedata   = cmd_data_q;
      m_byteenable  = cmd_be_q;
   end

   // Command register: a capture overwrites the entry that issues in the same
   // cycle, giving back-to-back commands without a bubble.
   always_comb begin
      cmd_valid_d = cmd_valid_q;
      cmd_kind_d  = cmd_kind_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_data_d  = cmd_data_q;
      cmd_be_d    = cmd_be_q;
      if (w_capture) begin
         cmd_valid_d = 1'b1;
         cmd_kind_d  = s_write ? CMD_WRITE : CMD_READ;
         cmd_addr_d  = s_address;
         cmd_data_d  = s_writedata;
         cmd_be_d    = s_byteenable;
      end else if (w_issue) begin
         cmd_valid_d = 1'b0;
      end
   end

   // Response path. Accept and timeout are mutually exclusive.
   always_comb begin
      rdv_d   = w_rsp_accept | w_rsp_timeout;
      rdata_d = rdata_q;
      if (w_rsp_timeout)     rdata_d = DATA_W'(c_default_rdata);
      else if (w_rsp_accept) rdata_d = m_readdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cmd_valid_q <= 1'b0;
         cmd_kind_q  <= CMD_READ;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
         cmd_be_q    <= '0;
         rdv_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_kind_q  <= cmd_kind_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_data_q  <= cmd_data_d;
         cmd_be_q    <= cmd_be_d;
         rdv_q       <= rdv_d;
         rdata_q     <= rdata_d;
      end
   end

   assign s_readdatavalid = rdv_q;
   assign s_readdata      = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mm_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_bridge
// Purpose  : Self-checking bench for mm_bridge: a table of single-command
//            vectors followed by hand-written multi-cycle sequences
//            (outstanding-read limit, downstream stall, dropped responses,
//            watchdog, reset with reads outstanding).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_address;
   logic        s_read, s_write;
   logic [31:0] s_writedata;
   logic [3:0]  s_byteenable;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic        s_readdatavalid;
   logic [31:0] m_address;
   logic        m_read, m_write;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteenable;
   logic        m_waitrequest;
   logic [31:0] m_readdata;
   logic        m_readdatavalid;
   logic        timeout_flag;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mm_bridge dut (
      .clk             (clk),
      .rst             (rst),
      .s_address       (s_address),
      .s_read          (s_read),
      .s_write         (s_write),
      .s_writedata     (s_writedata),
      .s_byteenable    (s_byteenable),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_byteenable    (m_byteenable),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .timeout_flag    (timeout_flag)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] rdata;   // downstream response for reads
      logic        exp_wr;  // expected kind on the master side
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // One command with idle downstream; reads answered two cycles after issue.
   task automatic apply_vec(input vec_t v);
      step();
      s_read = v.rd; s_write = v.wr; s_address = v.addr;
      s_writedata = v.data; s_byteenable = v.be;
      #1 chk("vec_accept_wait", s_waitrequest, 0);
      step();
      s_read = 0; s_write = 0;
      #1;
      chk("vec_m_write", m_write, v.exp_wr);
      chk("vec_m_read", m_read, !v.exp_wr);
      chk("vec_m_address", m_address, v.addr);
      chk("vec_m_be", m_byteenable, v.be);
      if (v.exp_wr) chk("vec_m_writedata", m_writedata, v.data);
      chk("vec_issue_wait", s_waitrequest, 0);
      step();
      chk("vec_no_repeat", {m_read, m_write}, 0);
      if (!v.exp_wr) begin
         step();
         chk("vec_rdv_early", s_readdatavalid, 0);
         m_readdatavalid = 1; m_readdata = v.rdata;
         step();
         m_readdatavalid = 0;
         chk("vec_rdv", s_readdatavalid, 1);
         chk("vec_rdata", s_readdata, v.rdata);
      end
   endtask

   initial begin
      int issued, stall, acc, cyc;

      vecs[0] = '{rd:0, wr:1, addr:32'h0000000C, data:32'h000000A5, be:4'hF, rdata:0, exp_wr:1};
      vecs[1] = '{rd:1, wr:0, addr:32'h00000004, data:0, be:4'hF, rdata:32'h11223344, exp_wr:0};
      vecs[2] = '{rd:0, wr:1, addr:32'h00000100, data:32'hDEADCAFE, be:4'h3, rdata:0, exp_wr:1};
      vecs[3] = '{rd:1, wr:0, addr:32'hFFFFFFFC, data:0, be:4'hF, rdata:32'hFFFFFFFF, exp_wr:0};
      vecs[4] = '{rd:1, wr:1, addr:32'h00000020, data:32'h12345678, be:4'h8, rdata:0, exp_wr:1};
      vecs[5] = '{rd:1, wr:0, addr:32'h00000000, data:0, be:4'h1, rdata:32'h00000000, exp_wr:0};

      rst = 0; s_address = 0; s_read = 0; s_write = 0; s_writedata = 0; s_byteenable = 0;
      m_waitrequest = 0; m_readdata = 0; m_readdatavalid = 0;

      // Reset state
      step();
      s_read = 1;
      #1;
      chk("rst_waitreq", s_waitrequest, 0);
      chk("rst_m_rdwr", {m_read, m_write}, 0);
      chk("rst_rdv", s_readdatavalid, 0);
      chk("rst_rdata", s_readdata, 0);
      chk("rst_tflag", timeout_flag, 0);
      s_read = 0;
      step();
      rst = 1;

      for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

      // Five back-to-back reads, downstream never answers
      issued = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (m_read && !m_waitrequest) issued++;
         s_read = 1; s_address = 32'h10 * (k + 1);
         #1 chk("b2b_accept", s_waitrequest, 0);
      end
      step();
      if (m_read && !m_waitrequest) issued++;
      s_read = 0;
      for (int k = 0; k < 3; k++) begin
         chk("b2b_held_read", m_read, 0);
         chk("b2b_held_wait", s_waitrequest, 1);
         step();
      end
      chk("b2b_issued", issued, 4);
      m_readdatavalid = 1; m_readdata = 32'hAAAA0001;
      step();
      m_readdatavalid = 0;
      chk("b2b_resp_rdv", s_readdatavalid, 1);
      chk("b2b_resp_data", s_readdata, 32'hAAAA0001);
      chk("b2b_release_read", m_read, 1);
      chk("b2b_release_addr", m_address, 32'h50);
      chk("b2b_release_wait", s_waitrequest, 0);
      step();
      chk("b2b_after_release", m_read, 0);
      for (int j = 0; j < 4; j++) begin
         m_readdatavalid = 1; m_readdata = 32'hB0 + j;
         step();
         m_readdatavalid = 0;
         chk("b2b_drain_rdv", s_readdatavalid, 1);
         chk("b2b_drain_data", s_readdata, 32'hB0 + j);
      end
      // Nothing outstanding now: a stray response must be dropped
      m_readdatavalid = 1; m_readdata = 32'h77;
      step();
      m_readdatavalid = 0;
      chk("drop_stray", s_readdatavalid, 0);

      // Downstream stall with a write in flight
      m_waitrequest = 1;
      s_write = 1; s_address = 32'h30; s_writedata = 32'h5A5A; s_byteenable = 4'hF;
      #1 chk("stall_accept", s_waitrequest, 0);
      step();
      s_write = 0;
      stall = 0; acc = 0;
      for (int c = 0; c < 6; c++) begin
         if (c != 0) step();
         if (c == 3) m_waitrequest = 0;
         #1;
         if (s_waitrequest) stall++;
         if (m_write && !m_waitrequest) acc++;
      end
      chk("stall_cycles", stall, 3);
      chk("stall_accepts", acc, 1);

      // Watchdog
      step();
      s_read = 1; s_address = 32'h44;
      step();
      s_read = 0;
      chk("wd_issue", m_read, 1);
      cyc = 0;
      while (!s_readdatavalid && cyc < 400) begin
         step();
         cyc++;
      end
`ifdef MM_BRIDGE_TIMEOUT_EN
      chk("wd_in_time", (cyc >= 256 && cyc <= 258), 1);
      chk("wd_rdv", s_readdatavalid, 1);
      chk("wd_data", s_readdata, 32'hDEADBEEF);
      chk("wd_flag", timeout_flag, 1);
      m_readdatavalid = 1; m_readdata = 32'h99;
      step();
      m_readdatavalid = 0;
      chk("wd_late_dropped", s_readdatavalid, 0);
      chk("wd_flag_sticky", timeout_flag, 1);
`else
      chk("nowd_no_rsp", cyc, 400);
      chk("nowd_flag", timeout_flag, 0);
      m_readdatavalid = 1; m_readdata = 32'h99;
      step();
      m_readdatavalid = 0;
      chk("nowd_real_rsp", s_readdatavalid, 1);
      chk("nowd_real_data", s_readdata, 32'h99);
`endif

      // Reset with two reads outstanding and a write held
      step();
      s_read = 1; s_address = 32'h60;
      step();
      s_address = 32'h64;
      step();
      s_read = 0;
      step();
      m_waitrequest = 1; s_write = 1; s_address = 32'h70;
      step();
      s_write = 0;
      chk("mid_write_held", m_write, 1);
      rst = 0;
      #1;
      chk("mid_rst_wait", s_waitrequest, 0);
      chk("mid_rst_write", m_write, 0);
      step();
      rst = 1; m_waitrequest = 0;
      #1;
      chk("mid_discard", {m_read, m_write, s_waitrequest}, 0);
      m_readdatavalid = 1; m_readdata = 32'hCC;
      step();
      chk("mid_drop1", s_readdatavalid, 0);
      step();
      m_readdatavalid = 0;
      chk("mid_drop2", s_readdatavalid, 0);
      step();
      chk("mid_drop3", s_readdatavalid, 0);
      apply_vec(vecs[1]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
